// File: rtl/key_pkg.sv
// Shared definitions for the key conditioner: board-clock default timings,
// channel index names, repeat phase type and a counter-width helper.
package key_pkg;

   // Default timings for a 100 MHz board clock.
   localparam int DEF_DEB_CYCLES    = 1_000_000;   // 10 ms stable time
   localparam int DEF_REPEAT_DELAY  = 50_000_000;  // 500 ms before first repeat
   localparam int DEF_REPEAT_PERIOD = 10_000_000;  // 100 ms between repeats

   // Channel assignment of the board push-buttons.
   localparam int KEY_UP    = 0;
   localparam int KEY_DOWN  = 1;
   localparam int KEY_LEFT  = 2;
   localparam int KEY_RIGHT = 3;

   // Auto-repeat phase: waiting for the long first delay, or repeating.
   typedef enum logic {
      PH_FIRST    = 1'b0,
      PH_PERIODIC = 1'b1
   } rpt_phase_t;

   // Width of a counter that must reach max_count-1, with one bit of headroom.
   function automatic int cnt_width(input int max_count);
      return $clog2(max_count) + 1;
   endfunction

endpackage

// File: rtl/key_chan.sv
// Single key channel: two-flop synchroniser, stable-count debounce filter,
// registered press/release pulses and optional auto-repeat.
// Auto-repeat is built only when KEY_REPEAT_EN is defined.
module key_chan
   import key_pkg::*;
#(
   parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
   parameter bit ACTIVE_LOW    = 1'b0,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic level,
   output logic pos,
   output logic neg,
   output logic pos_next
);

   localparam int CW = cnt_width(DEB_CYCLES);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

   logic          d0, d1;
   logic [CW-1:0] cnt, cnt_next;
   logic          level_next;
   logic          flip;
   logic          neg_next;
   logic          rpt_fire;

   // Synchronise the polarity-corrected pin into the clock domain.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of the others (d1 gets the old d0).
      if (!rst_n) begin
         d0 <= 1'b0;
         d1 <= 1'b0;
      end else begin
         d0 <= key_raw ^ ACTIVE_LOW;
         d1 <= d0;
      end
   end

   // Debounce: accept d1 once it has differed from level for DEB_CYCLES edges.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      cnt_next   = cnt;
      level_next = level;
      flip       = 1'b0;
      if (d1 == level) begin
         cnt_next = '0;
      end else if (cnt == DEB_LAST) begin
         flip       = 1'b1;
         level_next = d1;
         cnt_next   = '0;
      end else begin
         cnt_next = cnt + CW'(1);
      end
   end

`ifdef KEY_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = cnt_width(RMAX);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   rpt_phase_t    phase, phase_next;
   logic [RW-1:0] rcnt, rcnt_next;

   // Repeat timing: long first delay after the press, then a fixed period.
   always_comb begin
      rcnt_next  = rcnt;
      phase_next = phase;
      rpt_fire   = 1'b0;
      if (flip || !level) begin
         // A press flip restarts the delay; a release flip suppresses repeats.
         rcnt_next  = '0;
         phase_next = PH_FIRST;
      end else if (phase == PH_FIRST && rcnt == DELAY_LAST) begin
         rpt_fire   = 1'b1;
         rcnt_next  = '0;
         phase_next = PH_PERIODIC;
      end else if (phase == PH_PERIODIC && rcnt == PERIOD_LAST) begin
         rpt_fire  = 1'b1;
         rcnt_next = '0;
      end else begin
         rcnt_next = rcnt + RW'(1);
      end
   end

   // Repeat state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt  <= '0;
         phase <= PH_FIRST;
      end else begin
         rcnt  <= rcnt_next;
         phase <= phase_next;
      end
   end
`else
   // Without auto-repeat the timing parameters have no effect.
   logic unused_repeat_cfg;
   assign rpt_fire          = 1'b0;
   assign unused_repeat_cfg = (REPEAT_DELAY + REPEAT_PERIOD) != 0;
`endif

   assign pos_next = (flip & d1) | rpt_fire;
   assign neg_next = flip & ~d1;

   // Debounce state and registered output pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
         pos   <= 1'b0;
         neg   <= 1'b0;
      end else begin
         cnt   <= cnt_next;
         level <= level_next;
         pos   <= pos_next;
         neg   <= neg_next;
      end
   end

endmodule

// File: rtl/key_debounce_edge.sv
// Multi-channel key conditioner: N_KEYS independent key_chan instances plus a
// registered any_pos that pulses in the same cycle as any key_pos.
// Define KEY_REPEAT_EN to build hardware auto-repeat into every channel.
module key_debounce_edge
   import key_pkg::*;
#(
   parameter int N_KEYS        = 4,
   parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
   parameter bit ACTIVE_LOW    = 1'b0,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_pos,
   output logic [N_KEYS-1:0] key_neg,
   output logic              any_pos
);

   logic [N_KEYS-1:0] pos_next;

   for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
      key_chan #(
         .DEB_CYCLES   (DEB_CYCLES),
         .ACTIVE_LOW   (ACTIVE_LOW),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .key_raw (key_raw[i]),
         .level   (key_level[i]),
         .pos     (key_pos[i]),
         .neg     (key_neg[i]),
         .pos_next(pos_next[i])
      );
   end

   // Register the OR of the next-cycle press pulses so any_pos lines up with key_pos.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) any_pos <= 1'b0;
      else        any_pos <= |pos_next;
   end

endmodule

// File: tb/tb_key_debounce_edge.sv
// Bench for key_debounce_edge: an active-high and an active-low instance share
// clock and reset; a window-based reference model predicts every output each
// cycle, and directed sequences check latency, glitch rejection, pulse spacing,
// auto-repeat (when KEY_REPEAT_EN is defined) and reset mid-filter.
module tb_key_debounce_edge;

   localparam int N   = 4;
   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RP  = 4;
   localparam int W   = DEB + 2;
`ifdef KEY_REPEAT_EN
   localparam bit RPT = 1'b1;
`else
   localparam bit RPT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] raw_hi, raw_lo;
   logic [N-1:0] lvl_hi, pos_hi, neg_hi, lvl_lo, pos_lo, neg_lo;
   logic         any_hi, any_lo;

   int n_cmp = 0;
   int n_bad = 0;
   bit sb_on = 1'b0;

   always #5 clk = ~clk;

   key_debounce_edge #(.N_KEYS(N), .DEB_CYCLES(DEB), .ACTIVE_LOW(1'b0),
                       .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut_hi (
      .clk(clk), .rst_n(rst_n), .key_raw(raw_hi), .key_level(lvl_hi),
      .key_pos(pos_hi), .key_neg(neg_hi), .any_pos(any_hi));

   key_debounce_edge #(.N_KEYS(N), .DEB_CYCLES(DEB), .ACTIVE_LOW(1'b1),
                       .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut_lo (
      .clk(clk), .rst_n(rst_n), .key_raw(raw_lo), .key_level(lvl_lo),
      .key_pos(pos_lo), .key_neg(neg_lo), .any_pos(any_lo));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Per channel: history of pressed-sense pin samples; a level is accepted when
   // the DEB samples seen by the filter (two edges old and older) all disagree
   // with the current level. Repeats are counted in held cycles since the press.
   bit hist  [2][N][W];
   bit m_lvl [2][N];
   bit m_pos [2][N];
   bit m_neg [2][N];
   int m_held[2][N];

   task automatic model_clear();
      for (int a = 0; a < 2; a++)
         for (int c = 0; c < N; c++) begin
            for (int j = 0; j < W; j++) hist[a][c][j] = 1'b0;
            m_lvl[a][c] = 1'b0; m_pos[a][c] = 1'b0; m_neg[a][c] = 1'b0; m_held[a][c] = 0;
         end
   endtask

   task automatic model_step();
      for (int a = 0; a < 2; a++)
         for (int c = 0; c < N; c++) begin
            bit p;
            bit accept;
            p = (a == 0) ? raw_hi[c] : ~raw_lo[c];
            for (int j = 0; j < W - 1; j++) hist[a][c][j] = hist[a][c][j+1];
            hist[a][c][W-1] = p;
            m_pos[a][c] = 1'b0;
            m_neg[a][c] = 1'b0;
            accept = 1'b1;
            for (int j = 0; j < DEB; j++)
               if (hist[a][c][j] == m_lvl[a][c]) accept = 1'b0;
            if (accept) begin
               m_lvl[a][c]  = ~m_lvl[a][c];
               m_pos[a][c]  = m_lvl[a][c];
               m_neg[a][c]  = ~m_lvl[a][c];
               m_held[a][c] = 0;
            end else if (m_lvl[a][c]) begin
               m_held[a][c]++;
               if (RPT && (m_held[a][c] == RD ||
                           (m_held[a][c] > RD && (m_held[a][c] - RD) % RP == 0)))
                  m_pos[a][c] = 1'b1;
            end
         end
   endtask

   function automatic logic [12:0] exp_vec(input int a);
      logic [N-1:0] l, p, n;
      for (int c = 0; c < N; c++) begin
         l[c] = m_lvl[a][c]; p[c] = m_pos[a][c]; n[c] = m_neg[a][c];
      end
      return {l, p, n, |p};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_clear();
      else        model_step();
   end

   // Cycle-by-cycle scoreboard, sampled on the inactive edge.
   always @(negedge clk) begin
      if (sb_on) begin
         check("sb_hi", {19'd0, lvl_hi, pos_hi, neg_hi, any_hi}, {19'd0, exp_vec(0)});
         check("sb_lo", {19'd0, lvl_lo, pos_lo, neg_lo, any_lo}, {19'd0, exp_vec(1)});
      end
   end

   // Observe one channel for n cycles: pulse counts, first pulse cycles, any_pos then.
   task automatic watch(input int n, input bit lo, input int ch,
                        output int np, output int nn, output int fp, output int fn,
                        output bit any_fp);
      np = 0; nn = 0; fp = -1; fn = -1; any_fp = 1'b0;
      for (int i = 1; i <= n; i++) begin
         logic p, q, y;
         @(negedge clk);
         p = lo ? pos_lo[ch] : pos_hi[ch];
         q = lo ? neg_lo[ch] : neg_hi[ch];
         y = lo ? any_lo : any_hi;
         if (p) begin
            np++;
            if (fp < 0) begin fp = i; any_fp = y; end
         end
         if (q) begin
            nn++;
            if (fn < 0) fn = i;
         end
      end
   endtask

   int np, nn, fp, fn, tot;
   bit any_fp;
   int hold_t[2][N];
   int rst_t;

   initial begin
      rst_n  = 1'b1;
      raw_hi = '0;
      raw_lo = '1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      sb_on = 1'b1;
      check("rst_hi", {19'd0, lvl_hi, pos_hi, neg_hi, any_hi}, 32'd0);
      check("rst_lo", {19'd0, lvl_lo, pos_lo, neg_lo, any_lo}, 32'd0);
      #1 rst_n = 1'b1;

      // Active-low pins idle high through reset release: no spurious edges.
      watch(10, 1'b1, 3, np, nn, fp, fn, any_fp);
      check("al_idle_pos", np, 0);
      check("al_idle_neg", nn, 0);

      // ch0 press: pulse after edge 2+DEB, then hold and release.
      #1 raw_hi[0] = 1'b1;
      watch(8, 1'b0, 0, np, nn, fp, fn, any_fp);
      check("ch0_press_lat", fp, 6);
      check("ch0_press_cnt", np, 1);
      check("ch0_level", {28'd0, lvl_hi}, 32'h1);
      watch(26, 1'b0, 0, np, nn, fp, fn, any_fp);
      check("ch0_repeats", np, RPT ? 5 : 0);
      #1 raw_hi[0] = 1'b0;
      watch(10, 1'b0, 0, np, nn, fp, fn, any_fp);
      check("ch0_rel_neg", nn, 1);
      check("ch0_rel_lat", fn, 6);
      check("ch0_rel_pos", np, RPT ? 1 : 0);

      // ch1 glitches 3 high, 1 low, 3 high: all shorter than DEB, rejected.
      tot = 0;
      for (int i = 0; i < 8; i++) begin
         #1 raw_hi[1] = (i != 3 && i != 7);
         watch(1, 1'b0, 1, np, nn, fp, fn, any_fp);
         tot += np + nn;
      end
      watch(10, 1'b0, 1, np, nn, fp, fn, any_fp);
      tot += np + nn;
      check("ch1_glitch_pulses", tot, 0);
      check("ch1_glitch_level", lvl_hi[1], 1'b0);

      // ch2 press then release: press and release pulses 20 cycles apart.
      #1 raw_hi[2] = 1'b1;
      watch(8, 1'b0, 2, np, nn, fp, fn, any_fp);
      check("ch2_press_lat", fp, 6);
      tot = 8 - fp;
      watch(12, 1'b0, 2, np, nn, fp, fn, any_fp);
      #1 raw_hi[2] = 1'b0;
      watch(10, 1'b0, 2, np, nn, fp, fn, any_fp);
      check("ch2_gap", tot + 12 + fn, 20);
      check("ch2_neg_cnt", nn, 1);

      // Active-low ch3 pressed: key_pos and any_pos in the same cycle.
      #1 raw_lo[3] = 1'b0;
      watch(8, 1'b1, 3, np, nn, fp, fn, any_fp);
      check("al_ch3_lat", fp, 6);
      check("al_ch3_any", any_fp, 1'b1);

      // Reset mid-filter (cnt=2) with a key held: cleared, then a fresh press.
      #1 raw_hi[3] = 1'b1;
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("midrst_hi", {19'd0, lvl_hi, pos_hi, neg_hi, any_hi}, 32'd0);
      check("midrst_lo", {19'd0, lvl_lo, pos_lo, neg_lo, any_lo}, 32'd0);
      #1 rst_n = 1'b1;
      watch(8, 1'b0, 3, np, nn, fp, fn, any_fp);
      check("midrst_lat", fp, 6);
      check("midrst_cnt", np, 1);

      // Random phase: per-pin hold times mixing glitches, short and long presses.
      for (int a = 0; a < 2; a++)
         for (int c = 0; c < N; c++) hold_t[a][c] = $urandom_range(0, 5);
      rst_t = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            if (rst_t == 0) rst_n = 1'b1;
            else rst_t--;
         end else if ($urandom_range(0, 599) == 0) begin
            rst_n = 1'b0;
            rst_t = $urandom_range(0, 2);
         end
         for (int a = 0; a < 2; a++)
            for (int c = 0; c < N; c++) begin
               if (hold_t[a][c] == 0) begin
                  int r;
                  if (a == 0) raw_hi[c] = ~raw_hi[c];
                  else        raw_lo[c] = ~raw_lo[c];
                  r = $urandom_range(0, 9);
                  if (r < 4)      hold_t[a][c] = $urandom_range(0, 3);
                  else if (r < 7) hold_t[a][c] = $urandom_range(3, 10);
                  else            hold_t[a][c] = $urandom_range(20, 45);
               end else begin
                  hold_t[a][c]--;
               end
            end
      end
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      sb_on = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/key_debounce_edge.md
# key_debounce_edge

Multi-channel key conditioner for the board push-buttons: synchronises each raw key input, debounces it with a per-channel stable-count filter, and produces single-cycle press and release pulses plus a clean level. It sits between the board pins and the game-control logic (movement, restart, level select), replacing per-key edge detection with one parametrised block. Optional hardware auto-repeat generates extra press pulses while a key is held.

## Interface
- N_KEYS, 4, number of independent key channels
- DEB_CYCLES, 1000000, consecutive clk cycles a new level must persist before acceptance (≥1; 10 ms at 100 MHz)
- ACTIVE_LOW, 0, 1 = raw pin reads 0 when pressed; inversion applied before the synchroniser
- REPEAT_DELAY, 50000000, held cycles after the press pulse before the first repeat pulse (REPEAT_EN only, ≥1)
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses (REPEAT_EN only, ≥1)

- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- key_raw  input  N_KEYS  raw, asynchronous key pins
- key_level  output  N_KEYS  debounced level, 1 = pressed
- key_pos  output  N_KEYS  one-cycle press pulse (plus repeat pulses)
- key_neg  output  N_KEYS  one-cycle release pulse
- any_pos  output  1  OR of key_pos, same cycle

## Operation
- Per channel: p = key_raw ^ ACTIVE_LOW; two-flop synchroniser d0 <= p, d1 <= d0; d1 is the sampled level s.
- Debounce counter cnt, width $clog2(DEB_CYCLES)+1: if s == key_level, cnt <= 0; else if cnt == DEB_CYCLES-1, key_level <= s and cnt <= 0 (flip); else cnt <= cnt+1.
- Any glitch returning s to key_level before acceptance clears cnt; filtering restarts from zero.
- On the flip edge: key_pos <= 1 if s == 1, key_neg <= 1 if s == 0; otherwise both 0 next edge. Pulses registered, never combinational from key_raw.
- Channels fully independent; simultaneous events on several channels produce simultaneous pulses.
- any_pos registered alongside key_pos (same cycle, no extra latency).

## Timing
- Reset: d0, d1, key_level, cnt, key_pos, key_neg, any_pos, repeat state all 0 (idle level after polarity), so an unpressed active-low key gives no spurious edge after reset release.
- Latency: edge 1 = first clk edge sampling the new raw level held stable; key_pos/key_neg high for exactly one cycle after edge 2+DEB_CYCLES.
- DEB_CYCLES = 1: flip at edge 3 (synchroniser only).
- Pulses never overlap for one channel: key_pos and key_neg mutually exclusive; min spacing DEB_CYCLES cycles.
- Reset asserted mid-filter or mid-hold: all state cleared immediately; a key still held at release is reported as a fresh press after normal latency.

## Configuration
- KEY_REPEAT_EN defined: per-channel repeat counter rcnt (width for max(REPEAT_DELAY, REPEAT_PERIOD)) and phase bit (FIRST/PERIODIC). On press flip rcnt <= 0, phase FIRST. While key_level == 1: rcnt increments; in FIRST at rcnt == REPEAT_DELAY-1 → key_pos pulse, rcnt <= 0, phase PERIODIC; in PERIODIC at rcnt == REPEAT_PERIOD-1 → key_pos pulse, rcnt <= 0. Release flip clears rcnt/phase in the same edge as key_neg; no repeat pulse on that edge. key_neg never repeats.
- KEY_REPEAT_EN undefined: repeat logic absent; exactly one key_pos per debounced press; REPEAT_* parameters ignored.

## Structure
- Shared package key_pkg: default DEB_CYCLES/REPEAT_* constants per 100 MHz board clock, channel index constants (KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT), localparam counter-width helper.
- One sub-module key_chan: synchroniser, debounce, pulse and optional repeat for a single channel; top instantiates N_KEYS copies via generate and ORs key_pos into any_pos.

## Test plan
- DEB_CYCLES=4, ch0 rises at edge 1 and holds → key_pos[0] high only after edge 6, key_level[0]=1 from the same cycle; other channels stay 0.
- DEB_CYCLES=4, ch1 pulses high for 3 cycles, low 1, high 3 → no key_pos[1], key_level[1] stays 0.
- ch2 press then release after 20 cycles → one key_pos[2], one key_neg[2] 20 cycles apart, never same cycle.
- ACTIVE_LOW=1, key_raw=all 1s through reset release → no pulses; drive ch3 to 0 → key_pos[3] after DEB_CYCLES+2 edges, any_pos same cycle.
- KEY_REPEAT_EN, DELAY=10, PERIOD=4, hold ch0 for 30 cycles after press pulse → repeat pulses at +10, +14, +18, +22, +26; release → key_neg only, no further pulses.
- Assert rst_n low mid-filter (cnt=2) with key held, release → all outputs 0 during reset, single key_pos after full latency.
